pipe_fwd_stage: RTL and testbench
=================================

# pipe_fwd_stage

Parametrised ID→EX pipeline stage register with valid/ready handshake, flush, and per-operand priority forwarding. Generalises the fixed two-operand, three-source ID/EX register to NUM_OPS operands and NUM_FWD forwarding sources. It sits between decode and execute and replaces stop/jump bubble logic with a standard handshake plus flush. It also records, per operand, which forwarding source was used, and counts bubbles inserted.

## Interface
- DATA_W, 32, operand/forward data width
- CTRL_W, 64, width of opaque control bundle (pc, imm, ALU op, sels, …)
- NUM_OPS, 2, number of register operands
- NUM_FWD, 3, number of forwarding sources; index 0 = highest priority (EX), then MEM, WB
- ZERO_BUBBLE, 1, 1 = payload forced to zero whenever a bubble is loaded
- SRC_W, $clog2(NUM_FWD+1), derived; width of one fwd_src field
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept this cycle
- ctrl_i  in  CTRL_W  control bundle from decode
- op_i  in  NUM_OPS*DATA_W  register-file read values; operand k at [k*DATA_W +: DATA_W]
- fwd_hit_i  in  NUM_OPS*NUM_FWD  hazard hits; bit k*NUM_FWD+j = operand k matches source j
- fwd_data_i  in  NUM_FWD*DATA_W  forwarding data; source j at [j*DATA_W +: DATA_W]
- flush  in  1  kill the incoming instruction and the held entry (branch/jump)
- out_valid  out  1  registered; entry holds a real instruction (inverse of old bubble flag)
- out_ready  in  1  execute accepts the entry
- ctrl_o  out  CTRL_W  registered control bundle
- op_o  out  NUM_OPS*DATA_W  registered resolved operands
- fwd_src_o  out  NUM_OPS*SRC_W  registered; per operand, 0 = register file, j+1 = source j
- cnt_clr  in  1  synchronous clear of bubble counter
- bubble_cnt_o  out  16  saturating count of bubbles loaded

## Operation
- in_ready = ~out_valid | out_ready. This path is combinational and independent of in_valid and flush.
- Forward mux per operand k: select the lowest j with fwd_hit_i[k*NUM_FWD+j]=1, giving fwd_data_i source j and src j+1. With no hit, select op_i operand k and src 0.
- Priority on each rising edge, highest first:
  - flush=1: out_valid←0; if ZERO_BUBBLE, then ctrl_o/op_o/fwd_src_o←0; count a bubble. This overrides a simultaneous load and any hold.
  - in_valid & in_ready: load ctrl_i, the muxed operands, and the src codes; out_valid←1.
  - in_ready & ~in_valid: out_valid←0; zero the payload if ZERO_BUBBLE, else keep it; count a bubble.
  - ~in_ready (valid entry, out_ready=0): hold all outputs unchanged; the counter does not increment.
- Held entries are not re-forwarded. Operands were resolved at capture.
- Counter: +1 per bubble load and saturates at 0xFFFF. cnt_clr=1 sets it to 0 and overrides an increment in the same cycle.
- Reset (reset=0, async): out_valid=0; ctrl_o, op_o, fwd_src_o, bubble_cnt_o all 0. Deassertion is synchronised by the user; the first edge after release follows normal rules.

## Timing
- Latency: 1 cycle from accepted input to out_valid/outputs.
- Throughput: 1 instruction/cycle when out_ready is held high.
- All outputs except in_ready are registered. in_ready depends only on out_valid and out_ready.
- Back-pressure: an entry with out_valid=1 and out_ready=0 is stable indefinitely.
- Flush during a stall discards the held entry on that edge. in_ready is high in the next cycle.
- Width rule: operands pass through unmodified. No sign extension or truncation.

## Test plan
- Reset: assert reset mid-stream with out_valid=1 and count 5. Required: outputs 0 immediately, without a clock edge; in_ready=1.
- Forward priority (defaults): op_i={0x22,0x11}, fwd_data={WB 0x300, MEM 0x200, EX 0x100}, hits op0={MEM,WB}, op1=none, in_valid=1. Required next cycle: op_o[0]=0x200, op_o[1]=0x22, fwd_src_o={0,2}.
- Stall/hold: load ctrl 0xABCD, then out_ready=0 for 3 cycles while in_valid=1 with new data. Required: in_ready=0, outputs stay 0xABCD, counter unchanged. The new instruction loads on the first edge after out_ready=1.
- Flush vs load: flush=1 and in_valid=1 in the same cycle. Required: out_valid=0, payload 0, count +1, instruction dropped.
- Bubble drain: out_ready=1, in_valid=0 for 4 cycles from count 0. Required: count=4. Then cnt_clr with a bubble in the same cycle gives count=0.
- Saturation: preload the counter by running 65540 bubbles. Required: bubble_cnt_o=0xFFFF and stays there.

Source files
------------

// File: rtl/pipe_fwd_stage.sv
// ID->EX pipeline register with valid/ready handshake, flush, per-operand
// priority forwarding (lowest source index wins) and a saturating bubble counter.
module pipe_fwd_stage #(
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 64,
  parameter int NUM_OPS     = 2,
  parameter int NUM_FWD     = 3,
  parameter int ZERO_BUBBLE = 1,
  parameter int SRC_W       = $clog2(NUM_FWD + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [NUM_OPS*DATA_W-1:0]  op_i,
  input  logic [NUM_OPS*NUM_FWD-1:0] fwd_hit_i,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data_i,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [NUM_OPS*DATA_W-1:0]  op_o,
  output logic [NUM_OPS*SRC_W-1:0]   fwd_src_o,
  input  logic                       cnt_clr,
  output logic [15:0]                bubble_cnt_o
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                      vld_q, vld_d;
  logic [CTRL_W-1:0]         ctrl_q, ctrl_d;
  logic [NUM_OPS*DATA_W-1:0] op_q, op_d;
  logic [NUM_OPS*SRC_W-1:0]  src_q, src_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [NUM_OPS*DATA_W-1:0] op_mux;
  logic [NUM_OPS*SRC_W-1:0]  src_mux;
  logic                      bubble;

  assign in_ready = ~vld_q | out_ready;

  // Scan sources from lowest priority upward so the lowest hit index wins.
  always_comb begin
    op_mux  = op_i;
    src_mux = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      for (int j = NUM_FWD - 1; j >= 0; j--) begin
        if (fwd_hit_i[k*NUM_FWD + j]) begin
          op_mux[k*DATA_W +: DATA_W] = fwd_data_i[j*DATA_W +: DATA_W];
          src_mux[k*SRC_W +: SRC_W]  = SRC_W'(j + 1);
        end
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    op_d   = op_q;
    src_d  = src_q;
    bubble = 1'b0;
    if (flush || (in_ready && !in_valid)) begin
      vld_d  = 1'b0;
      bubble = 1'b1;
      if (ZERO_BUBBLE != 0) begin
        ctrl_d = '0;
        op_d   = '0;
        src_d  = '0;
      end
    end else if (in_ready) begin
      vld_d  = 1'b1;
      ctrl_d = ctrl_i;
      op_d   = op_mux;
      src_d  = src_mux;
    end
    if (cnt_clr)     cnt_d = '0;
    else if (bubble) cnt_d = sat_inc(cnt_q);
    else             cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      op_q   <= '0;
      src_q  <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      op_q   <= op_d;
      src_q  <= src_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid    = vld_q;
  assign ctrl_o       = ctrl_q;
  assign op_o         = op_q;
  assign fwd_src_o    = src_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_fwd_stage.sv
// Bench for pipe_fwd_stage: directed scenarios plus randomized traffic
// against a transaction-level model of the stage.
module tb_pipe_fwd_stage;
  localparam int DW = 32;
  localparam int CW = 64;
  localparam int NO = 2;
  localparam int NF = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, flush, out_valid, out_ready, cnt_clr;
  logic [CW-1:0]   ctrl_i, ctrl_o;
  logic [NO*DW-1:0] op_i, op_o;
  logic [NO*NF-1:0] fwd_hit_i;
  logic [NF*DW-1:0] fwd_data_i;
  logic [NO*SW-1:0] fwd_src_o;
  logic [15:0]     bubble_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit            m_valid;
  logic [CW-1:0] m_ctrl;
  logic [DW-1:0] m_op [NO];
  int            m_src [NO];
  int            m_cnt;

  pipe_fwd_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_i(ctrl_i), .op_i(op_i), .fwd_hit_i(fwd_hit_i), .fwd_data_i(fwd_data_i),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ctrl_o(ctrl_o),
    .op_o(op_o), .fwd_src_o(fwd_src_o), .cnt_clr(cnt_clr), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic model_clear_payload();
    m_ctrl = '0;
    for (int k = 0; k < NO; k++) begin
      m_op[k]  = '0;
      m_src[k] = 0;
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    model_clear_payload();
    m_cnt = 0;
  endtask

  task automatic model_update();
    bit rdy, bub;
    rdy = !m_valid || out_ready;
    bub = 1'b0;
    if (flush) begin
      m_valid = 1'b0;
      model_clear_payload();
      bub = 1'b1;
    end else if (rdy && in_valid) begin
      m_valid = 1'b1;
      m_ctrl  = ctrl_i;
      for (int k = 0; k < NO; k++) begin
        bit found;
        found    = 1'b0;
        m_op[k]  = op_i[k*DW +: DW];
        m_src[k] = 0;
        for (int j = 0; j < NF; j++) begin
          if (!found && fwd_hit_i[k*NF + j]) begin
            found    = 1'b1;
            m_op[k]  = fwd_data_i[j*DW +: DW];
            m_src[k] = j + 1;
          end
        end
      end
    end else if (rdy) begin
      m_valid = 1'b0;
      model_clear_payload();
      bub = 1'b1;
    end
    if (cnt_clr) m_cnt = 0;
    else if (bub && m_cnt < 65535) m_cnt = m_cnt + 1;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; cnt_clr = 0; out_ready = 1;
    ctrl_i = '0; op_i = '0; fwd_hit_i = '0; fwd_data_i = '0;
  endtask

  task automatic test_reset();
    // Power-on state
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL por_valid: got %b want 0", out_valid); end
    vectors++; if (bubble_cnt_o !== 16'h0) begin miscompares++; $display("FAIL por_cnt: got %h want 0", bubble_cnt_o); end
    #1 reset = 1'b1;
    // Build a state with a valid entry and count 5
    cnt_clr = 1; tick(); cnt_clr = 0;
    repeat (5) tick();
    in_valid = 1; ctrl_i = 64'hDEAD_BEEF_0000_0042; op_i = {32'h5, 32'h6};
    tick();
    in_valid = 0; out_ready = 0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL pre_rst_valid: got %b want 1", out_valid); end
    vectors++; if (bubble_cnt_o !== 16'd5) begin miscompares++; $display("FAIL pre_rst_cnt: got %0d want 5", bubble_cnt_o); end
    #1 reset = 1'b0;
    #1;
    model_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    vectors++; if (ctrl_o !== '0) begin miscompares++; $display("FAIL rst_ctrl: got %h want 0", ctrl_o); end
    vectors++; if (op_o !== '0) begin miscompares++; $display("FAIL rst_op: got %h want 0", op_o); end
    vectors++; if (fwd_src_o !== '0) begin miscompares++; $display("FAIL rst_src: got %h want 0", fwd_src_o); end
    vectors++; if (bubble_cnt_o !== 16'h0) begin miscompares++; $display("FAIL rst_cnt: got %h want 0", bubble_cnt_o); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    #1 reset = 1'b1;
    out_ready = 1;
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    in_valid   = 1;
    ctrl_i     = 64'h77;
    op_i       = {32'h22, 32'h11};
    fwd_data_i = {32'h300, 32'h200, 32'h100};
    fwd_hit_i  = 6'b000_110;
    tick();
    vectors++; if (op_o[31:0] !== 32'h200) begin miscompares++; $display("FAIL fwd_op0: got %h want 200", op_o[31:0]); end
    vectors++; if (op_o[63:32] !== 32'h22) begin miscompares++; $display("FAIL fwd_op1: got %h want 22", op_o[63:32]); end
    vectors++; if (fwd_src_o !== 4'b0010) begin miscompares++; $display("FAIL fwd_src: got %b want 0010", fwd_src_o); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fwd_valid: got %b want 1", out_valid); end
    // All sources hit on op1: EX must win
    fwd_hit_i = 6'b111_000;
    tick();
    vectors++; if (op_o[63:32] !== 32'h100) begin miscompares++; $display("FAIL fwd_all_op1: got %h want 100", op_o[63:32]); end
    vectors++; if (fwd_src_o !== 4'b0100) begin miscompares++; $display("FAIL fwd_all_src: got %b want 0100", fwd_src_o); end
  endtask

  task automatic test_stall();
    int c;
    idle_inputs();
    in_valid = 1; ctrl_i = 64'hABCD;
    tick();
    c = m_cnt;
    out_ready = 0; ctrl_i = 64'h1234; op_i = {32'h9, 32'h8};
    repeat (3) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
      tick();
      vectors++; if (ctrl_o !== 64'hABCD) begin miscompares++; $display("FAIL stall_ctrl: got %h want abcd", ctrl_o); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid: got %b want 1", out_valid); end
      vectors++; if (bubble_cnt_o !== 16'(c)) begin miscompares++; $display("FAIL stall_cnt: got %0d want %0d", bubble_cnt_o, c); end
    end
    out_ready = 1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    tick();
    vectors++; if (ctrl_o !== 64'h1234) begin miscompares++; $display("FAIL release_ctrl: got %h want 1234", ctrl_o); end
  endtask

  task automatic test_flush();
    int c;
    idle_inputs();
    in_valid = 1; ctrl_i = 64'h5555; op_i = {32'h3, 32'h4}; fwd_hit_i = 6'b001_001;
    tick();
    c = m_cnt;
    out_ready = 0; flush = 1; ctrl_i = 64'h7777;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    vectors++; if (ctrl_o !== '0) begin miscompares++; $display("FAIL flush_ctrl: got %h want 0", ctrl_o); end
    vectors++; if (op_o !== '0) begin miscompares++; $display("FAIL flush_op: got %h want 0", op_o); end
    vectors++; if (fwd_src_o !== '0) begin miscompares++; $display("FAIL flush_src: got %h want 0", fwd_src_o); end
    vectors++; if (bubble_cnt_o !== 16'(c + 1)) begin miscompares++; $display("FAIL flush_cnt: got %0d want %0d", bubble_cnt_o, c + 1); end
    flush = 0; in_valid = 0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    tick();
    vectors++; if (ctrl_o !== '0) begin miscompares++; $display("FAIL flush_dropped: got %h want 0", ctrl_o); end
    out_ready = 1;
  endtask

  task automatic test_drain();
    idle_inputs();
    in_valid = 1; cnt_clr = 1; ctrl_i = 64'h99;
    tick();
    in_valid = 0; cnt_clr = 0;
    repeat (4) tick();
    vectors++; if (bubble_cnt_o !== 16'd4) begin miscompares++; $display("FAIL drain_cnt: got %0d want 4", bubble_cnt_o); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    vectors++; if (ctrl_o !== '0) begin miscompares++; $display("FAIL drain_ctrl: got %h want 0", ctrl_o); end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    vectors++; if (bubble_cnt_o !== 16'd0) begin miscompares++; $display("FAIL clr_vs_bubble: got %0d want 0", bubble_cnt_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      cnt_clr    = ($urandom_range(0, 31) == 0);
      ctrl_i     = {$urandom, $urandom};
      op_i       = {$urandom, $urandom};
      fwd_hit_i  = NO*NF'($urandom);
      fwd_data_i = {$urandom, $urandom, $urandom};
      #1;
      vectors++;
      if (in_ready !== (!m_valid || out_ready)) begin
        miscompares++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, (!m_valid || out_ready));
      end
      tick();
      vectors++; if (out_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid: got %b want %b", out_valid, m_valid); end
      vectors++; if (ctrl_o !== m_ctrl) begin miscompares++; $display("FAIL rnd_ctrl: got %h want %h", ctrl_o, m_ctrl); end
      for (int k = 0; k < NO; k++) begin
        vectors++;
        if (op_o[k*DW +: DW] !== m_op[k]) begin
          miscompares++; $display("FAIL rnd_op%0d: got %h want %h", k, op_o[k*DW +: DW], m_op[k]);
        end
        vectors++;
        if (fwd_src_o[k*SW +: SW] !== SW'(m_src[k])) begin
          miscompares++; $display("FAIL rnd_src%0d: got %0d want %0d", k, fwd_src_o[k*SW +: SW], m_src[k]);
        end
      end
      vectors++; if (bubble_cnt_o !== 16'(m_cnt)) begin miscompares++; $display("FAIL rnd_cnt: got %0d want %0d", bubble_cnt_o, m_cnt); end
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    repeat (65534) tick();
    vectors++; if (bubble_cnt_o !== 16'hFFFE) begin miscompares++; $display("FAIL sat_pre: got %h want fffe", bubble_cnt_o); end
    tick();
    vectors++; if (bubble_cnt_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hit: got %h want ffff", bubble_cnt_o); end
    repeat (5) tick();
    vectors++; if (bubble_cnt_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h want ffff", bubble_cnt_o); end
    vectors++; if (bubble_cnt_o !== 16'(m_cnt)) begin miscompares++; $display("FAIL sat_model: got %h want %h", bubble_cnt_o, m_cnt); end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_fwd_priority();
    test_stall();
    test_flush();
    test_drain();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
